// File: rtl/pu_riscv_lsu_amo.sv
// pu_riscv_lsu_amo
//   Load/store unit with RV-A atomics for the PU-RISCV execute stage.
//   Plain loads and stores issue in one cycle and never stall. LR/SC and
//   the nine AMOs are sequenced by a small FSM as a read and/or a write on
//   the data-memory port, with the pipeline held via lsu_stall meanwhile.
//   One load-reservation is tracked at 2**RSV_GRAN byte granularity.
//
// Ports
//   clk, rstn                   clock, async active-low reset
//   ex_stall                    execute stall, blocks issue while IDLE
//   lsu_stall                   LSU holds the pipeline (atomic in flight)
//   id_bubble, id_instr         instruction valid (inverted) and encoding
//   id/ex/mem/wb_exception      upstream exceptions, any bit blocks issue
//   lsu_bubble, lsu_r           result valid (inverted), AMO/LR old value or SC status
//   lsu_exception               registered id_exception OR atomic fault causes
//   opA, opB                    rs1/base, rs2/offset/store data
//   st_xlen                     current XLEN mode
//   dmem_*                      data-memory request/response
module pu_riscv_lsu_amo #(
   parameter int XLEN           = 64,
   parameter int ILEN           = 64,
   parameter int EXCEPTION_SIZE = 16,
   parameter int RSV_GRAN       = 3
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      ex_stall,
   output logic                      lsu_stall,
   input  logic                      id_bubble,
   input  logic [ILEN-1:0]           id_instr,
   input  logic [EXCEPTION_SIZE-1:0] id_exception,
   input  logic [EXCEPTION_SIZE-1:0] ex_exception,
   input  logic [EXCEPTION_SIZE-1:0] mem_exception,
   input  logic [EXCEPTION_SIZE-1:0] wb_exception,
   output logic                      lsu_bubble,
   output logic [XLEN-1:0]           lsu_r,
   output logic [EXCEPTION_SIZE-1:0] lsu_exception,
   input  logic [XLEN-1:0]           opA,
   input  logic [XLEN-1:0]           opB,
   input  logic [1:0]                st_xlen,
   output logic [XLEN-1:0]           dmem_adr,
   output logic [XLEN-1:0]           dmem_d,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [2:0]                dmem_size,
   input  logic                      dmem_ack,
   input  logic [XLEN-1:0]           dmem_q,
   input  logic                      dmem_misaligned,
   input  logic                      dmem_page_fault
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_AMO   = 7'b0101111;

   localparam logic [1:0] RV32I = 2'b01;

   localparam logic [2:0] BYTE       = 3'b000;
   localparam logic [2:0] HWORD      = 3'b001;
   localparam logic [2:0] WORD       = 3'b010;
   localparam logic [2:0] DWORD      = 3'b011;
   localparam logic [2:0] UNDEF_SIZE = 3'b111;

   localparam logic [4:0] AMO_LR   = 5'b00010;
   localparam logic [4:0] AMO_SC   = 5'b00011;
   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   localparam int CAUSE_MISALIGNED_LOAD  = 4;
   localparam int CAUSE_MISALIGNED_STORE = 6;
   localparam int CAUSE_LOAD_PAGE_FAULT  = 13;
   localparam int CAUSE_STORE_PAGE_FAULT = 15;

   typedef enum logic [1:0] {IDLE, AMO_RD, AMO_WR} state_t;

   state_t                      state_q;
   logic                        dmem_req_q, dmem_we_q;
   logic [XLEN-1:0]             dmem_adr_q, dmem_d_q;
   logic [2:0]                  dmem_size_q;
   logic                        lsu_stall_q, lsu_bubble_q;
   logic [XLEN-1:0]             lsu_r_q;
   logic [EXCEPTION_SIZE-1:0]   lsu_exc_q;
   logic                        rsv_vld_q;
   logic [XLEN-1:RSV_GRAN]      rsv_adr_q;
   logic [4:0]                  op_q;
   logic                        word_q, lr_q;
   logic [XLEN-1:0]             opb_q;

   // Byte-lane shift (in bits) for a given address
   function automatic logic [5:0] lane_sh(input logic [XLEN-1:0] a);
      if (XLEN == 64) return {a[2:0], 3'b000};
      else            return {1'b0, a[1:0], 3'b000};
   endfunction

   function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] op, input logic word,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      logic [31:0]     a32, b32, r32;
      r   = '0;
      a32 = a[31:0];
      b32 = b[31:0];
      r32 = '0;
      if (word) begin
         case (op)
            AMO_SWAP: r32 = b32;
            AMO_ADD : r32 = a32 + b32;
            AMO_XOR : r32 = a32 ^ b32;
            AMO_AND : r32 = a32 & b32;
            AMO_OR  : r32 = a32 | b32;
            AMO_MIN : r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
            AMO_MAX : r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
            AMO_MINU: r32 = (a32 < b32) ? a32 : b32;
            AMO_MAXU: r32 = (a32 > b32) ? a32 : b32;
            default : r32 = b32;
         endcase
         r[31:0] = r32;
      end else begin
         case (op)
            AMO_SWAP: r = b;
            AMO_ADD : r = a + b;
            AMO_XOR : r = a ^ b;
            AMO_AND : r = a & b;
            AMO_OR  : r = a | b;
            AMO_MIN : r = ($signed(a) < $signed(b)) ? a : b;
            AMO_MAX : r = ($signed(a) > $signed(b)) ? a : b;
            AMO_MINU: r = (a < b) ? a : b;
            AMO_MAXU: r = (a > b) ? a : b;
            default : r = b;
         endcase
      end
      return r;
   endfunction

   // Decode
   logic [6:0]                opcode;
   logic [2:0]                func3;
   logic [4:0]                func5;
   logic                      dw_ok, issue;
   logic [XLEN-1:0]           imm_s, adr_ld, adr_st, st_data, sc_data;
   logic [2:0]                ld_size, st_size;
   logic                      amo_size_ok, st_rsv_hit, sc_rsv_hit;
   logic [XLEN-1:0]           old_raw, old_val, wr_val;
   logic                      fault;
   logic [EXCEPTION_SIZE-1:0] flt_bits;
   logic                      unused_bits;

   assign unused_bits = ^id_instr;

   always_comb begin
      opcode  = id_instr[6:0];
      func3   = id_instr[14:12];
      func5   = id_instr[31:27];
      dw_ok   = (XLEN == 64) && (st_xlen != RV32I);
      issue   = (state_q == IDLE) && !ex_stall && !id_bubble &&
                ~|{id_exception, ex_exception, mem_exception, wb_exception};
      imm_s   = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      adr_ld  = opA + opB;
      adr_st  = opA + imm_s;
      st_data = opB << lane_sh(adr_st);
      sc_data = opB << lane_sh(opA);

      case (func3)
         3'b000, 3'b100: ld_size = BYTE;
         3'b001, 3'b101: ld_size = HWORD;
         3'b010:         ld_size = WORD;
         3'b110:         ld_size = dw_ok ? WORD  : UNDEF_SIZE;
         3'b011:         ld_size = dw_ok ? DWORD : UNDEF_SIZE;
         default:        ld_size = UNDEF_SIZE;
      endcase
      case (func3)
         3'b000:  st_size = BYTE;
         3'b001:  st_size = HWORD;
         3'b010:  st_size = WORD;
         3'b011:  st_size = dw_ok ? DWORD : UNDEF_SIZE;
         default: st_size = UNDEF_SIZE;
      endcase

      amo_size_ok = (func3 == 3'b010) || ((func3 == 3'b011) && dw_ok);
      st_rsv_hit  = rsv_vld_q && (rsv_adr_q == adr_st[XLEN-1:RSV_GRAN]);
      sc_rsv_hit  = rsv_vld_q && (rsv_adr_q == opA[XLEN-1:RSV_GRAN]);

      // Old value is taken from the addressed lane; W results are sign-extended
      old_raw = dmem_q >> lane_sh(dmem_adr_q);
      old_val = old_raw;
      if (word_q) begin
         old_val       = {XLEN{old_raw[31]}};
         old_val[31:0] = old_raw[31:0];
      end
      wr_val = amo_alu(op_q, word_q, old_raw, opb_q) << lane_sh(dmem_adr_q);

      fault    = dmem_req_q && (dmem_misaligned || dmem_page_fault);
      flt_bits = '0;
      if (lr_q) begin
         flt_bits[CAUSE_MISALIGNED_LOAD] = dmem_misaligned;
         flt_bits[CAUSE_LOAD_PAGE_FAULT] = dmem_page_fault;
      end else begin
         flt_bits[CAUSE_MISALIGNED_STORE] = dmem_misaligned;
         flt_bits[CAUSE_STORE_PAGE_FAULT] = dmem_page_fault;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_adr_q   <= '0;
         dmem_d_q     <= '0;
         dmem_size_q  <= UNDEF_SIZE;
         lsu_stall_q  <= 1'b0;
         lsu_bubble_q <= 1'b1;
         lsu_r_q      <= '0;
         lsu_exc_q    <= '0;
         rsv_vld_q    <= 1'b0;
         rsv_adr_q    <= '0;
         op_q         <= '0;
         word_q       <= 1'b0;
         lr_q         <= 1'b0;
         opb_q        <= '0;
      end else begin
         if (!lsu_stall_q) lsu_exc_q <= id_exception;

         case (state_q)
            IDLE: begin
               dmem_req_q   <= 1'b0;
               lsu_bubble_q <= 1'b1;
               if (issue) begin
                  if (opcode == OPC_LOAD) begin
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= 1'b0;
                     dmem_adr_q   <= adr_ld;
                     dmem_size_q  <= ld_size;
                     lsu_bubble_q <= 1'b0;
                  end else if (opcode == OPC_STORE) begin
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= 1'b1;
                     dmem_adr_q   <= adr_st;
                     dmem_size_q  <= st_size;
                     dmem_d_q     <= st_data;
                     lsu_bubble_q <= 1'b0;
                     if (st_rsv_hit) rsv_vld_q <= 1'b0;
                  end else if (opcode == OPC_AMO && amo_size_ok) begin
                     dmem_adr_q  <= opA;
                     dmem_size_q <= func3[0] ? DWORD : WORD;
                     op_q        <= func5;
                     word_q      <= ~func3[0];
                     lr_q        <= (func5 == AMO_LR);
                     opb_q       <= opB;
                     if (func5 == AMO_SC) begin
                        rsv_vld_q <= 1'b0;
                        if (sc_rsv_hit) begin
                           dmem_req_q  <= 1'b1;
                           dmem_we_q   <= 1'b1;
                           dmem_d_q    <= sc_data;
                           lsu_stall_q <= 1'b1;
                           lsu_r_q     <= '0;
                           state_q     <= AMO_WR;
                        end else begin
                           lsu_r_q      <= {{(XLEN-1){1'b0}}, 1'b1};
                           lsu_bubble_q <= 1'b0;
                        end
                     end else begin
                        dmem_req_q  <= 1'b1;
                        dmem_we_q   <= 1'b0;
                        lsu_stall_q <= 1'b1;
                        state_q     <= AMO_RD;
                     end
                  end
               end
            end

            AMO_RD: begin
               if (fault) begin
                  dmem_req_q   <= 1'b0;
                  lsu_stall_q  <= 1'b0;
                  lsu_bubble_q <= 1'b0;
                  lsu_exc_q    <= id_exception | flt_bits;
                  rsv_vld_q    <= 1'b0;
                  state_q      <= IDLE;
               end else if (dmem_ack) begin
                  lsu_r_q <= old_val;
                  if (lr_q) begin
                     dmem_req_q   <= 1'b0;
                     lsu_stall_q  <= 1'b0;
                     lsu_bubble_q <= 1'b0;
                     rsv_vld_q    <= 1'b1;
                     rsv_adr_q    <= dmem_adr_q[XLEN-1:RSV_GRAN];
                     state_q      <= IDLE;
                  end else begin
                     // request stays asserted, turning into the write half
                     dmem_we_q <= 1'b1;
                     dmem_d_q  <= wr_val;
                     state_q   <= AMO_WR;
                  end
               end
            end

            AMO_WR: begin
               if (fault) begin
                  dmem_req_q   <= 1'b0;
                  dmem_we_q    <= 1'b0;
                  lsu_stall_q  <= 1'b0;
                  lsu_bubble_q <= 1'b0;
                  lsu_exc_q    <= id_exception | flt_bits;
                  rsv_vld_q    <= 1'b0;
                  state_q      <= IDLE;
               end else if (dmem_ack) begin
                  dmem_req_q   <= 1'b0;
                  dmem_we_q    <= 1'b0;
                  lsu_stall_q  <= 1'b0;
                  lsu_bubble_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu_stall     = lsu_stall_q;
   assign lsu_bubble    = lsu_bubble_q;
   assign lsu_r         = lsu_r_q;
   assign lsu_exception = lsu_exc_q;
   assign dmem_adr      = dmem_adr_q;
   assign dmem_d        = dmem_d_q;
   assign dmem_req      = dmem_req_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_size     = dmem_size_q;

endmodule

// File: tb/tb_pu_riscv_lsu_amo.sv
// Directed bench for pu_riscv_lsu_amo: plain load/store issue, AMO
// read/write sequencing, LR/SC reservation handling, faults and reset.
module tb_pu_riscv_lsu_amo;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        ex_stall = 1'b0, lsu_stall;
   logic        id_bubble = 1'b1;
   logic [63:0] id_instr = '0;
   logic [15:0] id_exception = '0, ex_exception = '0, mem_exception = '0, wb_exception = '0;
   logic        lsu_bubble;
   logic [63:0] lsu_r;
   logic [15:0] lsu_exception;
   logic [63:0] opA = '0, opB = '0;
   logic [1:0]  st_xlen = 2'b10;
   logic [63:0] dmem_adr, dmem_d, dmem_q = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [2:0]  dmem_size;
   logic        dmem_misaligned = 1'b0, dmem_page_fault = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pu_riscv_lsu_amo #(.XLEN(64), .ILEN(64), .EXCEPTION_SIZE(16), .RSV_GRAN(3)) dut (
      .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .lsu_stall(lsu_stall),
      .id_bubble(id_bubble), .id_instr(id_instr),
      .id_exception(id_exception), .ex_exception(ex_exception),
      .mem_exception(mem_exception), .wb_exception(wb_exception),
      .lsu_bubble(lsu_bubble), .lsu_r(lsu_r), .lsu_exception(lsu_exception),
      .opA(opA), .opB(opB), .st_xlen(st_xlen),
      .dmem_adr(dmem_adr), .dmem_d(dmem_d), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_size(dmem_size), .dmem_ack(dmem_ack), .dmem_q(dmem_q),
      .dmem_misaligned(dmem_misaligned), .dmem_page_fault(dmem_page_fault));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_amo(input logic [4:0] f5, input logic [2:0] f3);
      return {f5, 2'b00, 5'd2, 5'd1, f3, 5'd3, 7'b0101111};
   endfunction

   function automatic logic [31:0] mk_store(input logic [2:0] f3, input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] mk_load(input logic [2:0] f3);
      return {12'd0, 5'd1, f3, 5'd3, 7'b0000011};
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
      id_instr  = {32'h0, ins};
      opA       = a;
      opB       = b;
      id_bubble = 1'b0;
      tick();
      id_bubble = 1'b1;
   endtask

   // read ack with data q, capture result and write data, then write ack
   task automatic amo_rw(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] q, output logic [63:0] r, output logic [63:0] wd);
      issue(ins, a, b);
      dmem_q = q; dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      r  = lsu_r;
      wd = dmem_d;
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
   endtask

   task automatic lr(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] q);
      issue(mk_amo(5'b00010, f3), a, 64'h0);
      dmem_q = q; dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
   endtask

   logic [63:0] r, wd;

   initial begin
      #2 rstn = 1'b0;
      #10;
      chk("rst_req",    {63'h0, dmem_req},   64'h0);
      chk("rst_stall",  {63'h0, lsu_stall},  64'h0);
      chk("rst_bubble", {63'h0, lsu_bubble}, 64'h1);
      chk("rst_r",      lsu_r,               64'h0);
      chk("rst_exc",    {48'h0, lsu_exception}, 64'h0);
      rstn = 1'b1;
      tick();

      // SW, misaligned offset 6 lands in the top lanes
      issue(mk_store(3'b010, 12'd6), 64'h1000, 64'hAABBCCDD);
      chk("sw_req",   {63'h0, dmem_req},  64'h1);
      chk("sw_we",    {63'h0, dmem_we},   64'h1);
      chk("sw_adr",   dmem_adr,           64'h1006);
      chk("sw_size",  {61'h0, dmem_size}, 64'h2);
      chk("sw_d",     dmem_d,             64'hCCDD_0000_0000_0000);
      chk("sw_stall", {63'h0, lsu_stall}, 64'h0);
      chk("sw_bub",   {63'h0, lsu_bubble}, 64'h0);
      tick();
      chk("sw_req1",   {63'h0, dmem_req},  64'h0);
      chk("sw_stall1", {63'h0, lsu_stall}, 64'h0);

      // LB: address = opA + opB
      issue(mk_load(3'b000), 64'h100, 64'h23);
      chk("lb_adr",  dmem_adr,           64'h123);
      chk("lb_size", {61'h0, dmem_size}, 64'h0);
      chk("lb_we",   {63'h0, dmem_we},   64'h0);

      // RV32 mode: LD undefined, AMO.D rejected
      st_xlen = 2'b01;
      issue(mk_load(3'b011), 64'h100, 64'h0);
      chk("ld32_size", {61'h0, dmem_size}, 64'h7);
      tick();
      issue(mk_amo(5'b00000, 3'b011), 64'h2000, 64'h1);
      chk("amod32_req", {63'h0, dmem_req},   64'h0);
      chk("amod32_bub", {63'h0, lsu_bubble}, 64'h1);
      chk("amod32_stl", {63'h0, lsu_stall},  64'h0);
      st_xlen = 2'b10;

      // blocked issue: ex_stall, then upstream exception
      ex_stall = 1'b1;
      issue(mk_store(3'b010, 12'd0), 64'h1000, 64'h1);
      chk("exst_req", {63'h0, dmem_req},   64'h0);
      chk("exst_bub", {63'h0, lsu_bubble}, 64'h1);
      ex_stall = 1'b0;
      id_exception = 16'h0004;
      issue(mk_store(3'b010, 12'd0), 64'h1000, 64'h1);
      chk("idexc_req", {63'h0, dmem_req},        64'h0);
      chk("idexc_exc", {48'h0, lsu_exception},   64'h4);
      id_exception = 16'h0;
      tick();
      chk("idexc_clr", {48'h0, lsu_exception},   64'h0);

      // AMOADD.W with slow read ack, ex_stall asserted mid-flight
      issue(mk_amo(5'b00000, 3'b010), 64'h2000, 64'h5);
      chk("add_req",   {63'h0, dmem_req},   64'h1);
      chk("add_we",    {63'h0, dmem_we},    64'h0);
      chk("add_size",  {61'h0, dmem_size},  64'h2);
      chk("add_adr",   dmem_adr,            64'h2000);
      chk("add_stall", {63'h0, lsu_stall},  64'h1);
      ex_stall = 1'b1;
      tick();
      tick();
      chk("add_hold",  {63'h0, dmem_req},   64'h1);
      chk("add_hstl",  {63'h0, lsu_stall},  64'h1);
      dmem_q = 64'h7FFF_FFFF; dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("add_r",     lsu_r,               64'h7FFF_FFFF);
      chk("add_wwe",   {63'h0, dmem_we},    64'h1);
      chk("add_wd",    {32'h0, dmem_d[31:0]}, 64'h8000_0004);
      chk("add_wstl",  {63'h0, lsu_stall},  64'h1);
      tick();
      chk("add_wreq",  {63'h0, dmem_req},   64'h1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      ex_stall = 1'b0;
      chk("add_dstl",  {63'h0, lsu_stall},  64'h0);
      chk("add_dbub",  {63'h0, lsu_bubble}, 64'h0);
      chk("add_dreq",  {63'h0, dmem_req},   64'h0);
      tick();
      chk("add_bub1",  {63'h0, lsu_bubble}, 64'h1);

      // signed vs unsigned min/max
      amo_rw(mk_amo(5'b10000, 3'b011), 64'h2800, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, r, wd);
      chk("mind_wd", wd, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("mind_r",  r,  64'hFFFF_FFFF_FFFF_FFFF);
      amo_rw(mk_amo(5'b11000, 3'b011), 64'h2800, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, r, wd);
      chk("minud_wd", wd, 64'h1);
      amo_rw(mk_amo(5'b10100, 3'b010), 64'h2800, 64'h5, 64'h8000_0000, r, wd);
      chk("maxw_wd", wd, 64'h5);
      chk("maxw_r",  r,  64'hFFFF_FFFF_8000_0000);
      amo_rw(mk_amo(5'b11100, 3'b010), 64'h2800, 64'h5, 64'h8000_0000, r, wd);
      chk("maxuw_wd", wd, 64'h8000_0000);
      // upper-lane word
      amo_rw(mk_amo(5'b00100, 3'b010), 64'h2804, 64'hFF, 64'h1234_5678_0000_0000, r, wd);
      chk("xorw_r",  r,  64'h1234_5678);
      chk("xorw_wd", wd, 64'h1234_5687_0000_0000);

      // LR.D / SC.D same granule succeeds, repeat SC fails
      lr(3'b011, 64'h3000, 64'h1234);
      chk("lrd_r",    lsu_r,               64'h1234);
      chk("lrd_stl",  {63'h0, lsu_stall},  64'h0);
      chk("lrd_bub",  {63'h0, lsu_bubble}, 64'h0);
      chk("lrd_req",  {63'h0, dmem_req},   64'h0);
      issue(mk_amo(5'b00011, 3'b011), 64'h3004, 64'h55);
      chk("scd_req",  {63'h0, dmem_req},   64'h1);
      chk("scd_we",   {63'h0, dmem_we},    64'h1);
      chk("scd_r",    lsu_r,               64'h0);
      chk("scd_stl",  {63'h0, lsu_stall},  64'h1);
      chk("scd_adr",  dmem_adr,            64'h3004);
      chk("scd_d",    dmem_d,              64'h0000_0055_0000_0000);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("scd_dstl", {63'h0, lsu_stall},  64'h0);
      chk("scd_dbub", {63'h0, lsu_bubble}, 64'h0);
      issue(mk_amo(5'b00011, 3'b011), 64'h3000, 64'h66);
      chk("sc2_req",  {63'h0, dmem_req},   64'h0);
      chk("sc2_r",    lsu_r,               64'h1);
      chk("sc2_bub",  {63'h0, lsu_bubble}, 64'h0);
      chk("sc2_stl",  {63'h0, lsu_stall},  64'h0);

      // store to reserved granule kills the reservation
      lr(3'b010, 64'h4000, 64'h8000_0000);
      chk("lrw_r", lsu_r, 64'hFFFF_FFFF_8000_0000);
      issue(mk_store(3'b010, 12'd0), 64'h4000, 64'h9);
      chk("sw4_req", {63'h0, dmem_req}, 64'h1);
      issue(mk_amo(5'b00011, 3'b010), 64'h4000, 64'h7);
      chk("sc4_req", {63'h0, dmem_req}, 64'h0);
      chk("sc4_r",   lsu_r,             64'h1);
      tick();
      chk("sc4_req1", {63'h0, dmem_req}, 64'h0);

      // page fault on AMO read (ack at the same time) aborts
      lr(3'b010, 64'h5000, 64'h0);
      issue(mk_amo(5'b00001, 3'b010), 64'h5000, 64'hAB);
      chk("pf_req0", {63'h0, dmem_req}, 64'h1);
      dmem_page_fault = 1'b1; dmem_ack = 1'b1;
      tick();
      dmem_page_fault = 1'b0; dmem_ack = 1'b0;
      chk("pf_req",  {63'h0, dmem_req},      64'h0);
      chk("pf_stl",  {63'h0, lsu_stall},     64'h0);
      chk("pf_exc",  {48'h0, lsu_exception}, 64'h8000);
      tick();
      chk("pf_req1", {63'h0, dmem_req},      64'h0);
      chk("pf_exc1", {48'h0, lsu_exception}, 64'h0);
      issue(mk_amo(5'b00011, 3'b010), 64'h5000, 64'h1);
      chk("pf_sc_r",   lsu_r,             64'h1);
      chk("pf_sc_req", {63'h0, dmem_req}, 64'h0);

      // misaligned LR reports a load cause
      issue(mk_amo(5'b00010, 3'b010), 64'h5002, 64'h0);
      dmem_misaligned = 1'b1;
      tick();
      dmem_misaligned = 1'b0;
      chk("mis_exc", {48'h0, lsu_exception}, 64'h0010);
      chk("mis_req", {63'h0, dmem_req},      64'h0);

      // reset in AMO_WR
      lr(3'b011, 64'h6000, 64'h0);
      issue(mk_amo(5'b00000, 3'b011), 64'h7000, 64'h1);
      dmem_q = 64'h5; dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("rwr_we", {63'h0, dmem_we}, 64'h1);
      #2 rstn = 1'b0;
      #1;
      chk("rwr_req", {63'h0, dmem_req},   64'h0);
      chk("rwr_stl", {63'h0, lsu_stall},  64'h0);
      chk("rwr_bub", {63'h0, lsu_bubble}, 64'h1);
      #2 rstn = 1'b1;
      tick();
      chk("rwr_req1", {63'h0, dmem_req}, 64'h0);
      issue(mk_amo(5'b00011, 3'b011), 64'h6000, 64'h1);
      chk("rwr_sc_r",   lsu_r,             64'h1);
      chk("rwr_sc_req", {63'h0, dmem_req}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
